button_debounce: RTL and testbench

//   Upstream conditioning stage for the button pulse generator.

---
 rtl/button_debounce_if.sv | 25 ++
 rtl/button_debounce.sv | 139 +++++++++++++
 tb/tb_button_debounce.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Button conditioning bus: raw button toward the debouncer, clean level and
// strobes back to the consumer.
interface button_debounce_if;
  logic button;
  logic btn_clean;
  logic btn_rise;
  logic btn_fall;
  logic long_press;

  modport master (
    output button,
    input  btn_clean,
    input  btn_rise,
    input  btn_fall,
    input  long_press
  );

  modport slave (
    input  button,
    output btn_clean,
    output btn_rise,
    output btn_fall,
    output long_press
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser and bounce filter producing a clean level plus rise/fall strobes.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to add a one-shot long_press strobe.
module button_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES     = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  button_debounce_if.slave   bus
);

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
`else
  localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_VAL  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_sync;
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_clean, r_rise, r_fall;
  logic                   w_clean_nxt, w_rise_nxt, w_fall_nxt;
  logic                   w_long_nxt;
  logic                   r_long;

  assign w_btn_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser, FSM state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.button};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_long  <= w_long_nxt;
    end
  end

  // Next state, stability counting and strobe generation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        w_cnt_nxt = '0;
        if (w_btn_sync) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!w_btn_sync) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!w_btn_sync) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
          // Count saturates at LONG_VAL so a held button strobes only once
          if (r_cnt != LONG_VAL) begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_long_nxt = (r_cnt == LONG_LAST);
          end
`else
          w_cnt_nxt = '0;
`endif
        end
      end
      WAIT_LOW: begin
        if (w_btn_sync) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    w_clean_nxt = (w_state_nxt == STABLE_HIGH) || (w_state_nxt == WAIT_LOW);
  end

  assign bus.btn_clean = r_clean;
  assign bus.btn_rise  = r_rise;
  assign bus.btn_fall  = r_fall;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  assign bus.long_press = r_long;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed plus randomized bench for button_debounce against a run-length reference model.
module tb_button_debounce;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   edge_no;

  button_debounce_if bus ();

  button_debounce dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: button is seen SYNC edges late; clean flips after DEB consecutive
  // disagreeing samples; long press after LONG agreeing high samples since the last settle.
  logic m_clean, m_rise, m_fall, m_long;
  int   m_run, m_hold;
  logic q[$];

  task automatic model_reset();
    q = {};
    for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
    m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
    m_run = 0; m_hold = 0;
  endtask

  task automatic model_edge(input logic b);
    logic s;
    s = q.pop_front();
    q.push_back(b);
    m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
    if (s !== m_clean) begin
      m_run++;
      m_hold = 0;
      if (m_run >= DEB) begin
        m_clean = s;
        m_rise  = s;
        m_fall  = !s;
        m_run   = 0;
      end
    end else if (m_run != 0) begin
      m_run  = 0;
      m_hold = 0;
    end else if (m_clean && m_hold < LONG) begin
      m_hold++;
      m_long = (m_hold == LONG);
    end
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    m_long = 1'b0;
`endif
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b edge=%0d t=%0t", tag, obs, exp, edge_no, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    if (rst) model_reset();
    else     model_edge(bus.button);
    #1;
    chk("clean", bus.btn_clean, m_clean);
    chk("rise",  bus.btn_rise,  m_rise);
    chk("fall",  bus.btn_fall,  m_fall);
    chk("long",  bus.long_press, m_long);
    chk("excl",  bus.btn_rise & bus.btn_fall, 1'b0);
  endtask

  task automatic set_btn(input logic v);
    #($urandom_range(0, 6));
    bus.button = v;
  endtask

  task automatic run_count(input int n, output int rises, output int falls, output int longs,
                           output int f_rise, output int f_fall, output int f_long);
    rises = 0; falls = 0; longs = 0; f_rise = -1; f_fall = -1; f_long = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bus.btn_rise)   begin rises++; if (f_rise < 0) f_rise = i; end
      if (bus.btn_fall)   begin falls++; if (f_fall < 0) f_fall = i; end
      if (bus.long_press) begin longs++; if (f_long < 0) f_long = i; end
    end
  endtask

  initial begin
    int r, f, l, fr, ff, fl;
    int br, bf, bl, d1, d2, d3;
    logic v;
    clk = 1'b0; rst = 1'b1; bus.button = 1'b1;
    n_chk = 0; n_fail = 0; edge_no = 0;
    model_reset();

    // Reset held with button high
    repeat (3) tick();
    chk("rst_clean", bus.btn_clean, 1'b0);
    chk("rst_rise",  bus.btn_rise,  1'b0);
    #3 rst = 1'b0;
    run_count(20, r, f, l, fr, ff, fl);
    chk_int("t1_rise_edge", fr, SYNC + DEB);
    chk_int("t1_rises", r, 1);
    chk_int("t1_falls", f, 0);

    // Clean release / press / release
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t2_fall_edge_a", ff, SYNC + DEB); chk_int("t2_falls_a", f, 1);
    set_btn(1'b1); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t2_rise_edge", fr, SYNC + DEB); chk_int("t2_rises", r, 1); chk_int("t2_no_fall", f, 0);
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t2_fall_edge", ff, SYNC + DEB); chk_int("t2_falls", f, 1); chk_int("t2_no_rise", r, 0);

    // Bounce then settle high
    br = 0; bf = 0; v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_btn(v);
      run_count($urandom_range(1, 2), r, f, l, d1, d2, d3);
      br += r; bf += f;
      v = !v;
    end
    set_btn(1'b1); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t3_rise_edge", fr, SYNC + DEB);
    chk_int("t3_rises", br + r, 1);
    chk_int("t3_falls", bf + f, 0);

    // High glitch while low, then low glitch while high
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);
    set_btn(1'b1); run_count(3, br, bf, bl, d1, d2, d3);
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t4_hi_glitch_rises", br + r, 0); chk_int("t4_hi_glitch_falls", bf + f, 0);
    chk("t4_hi_glitch_clean", bus.btn_clean, 1'b0);
    set_btn(1'b1); run_count(20, r, f, l, fr, ff, fl);
    set_btn(1'b0); run_count(3, br, bf, bl, d1, d2, d3);
    set_btn(1'b1); run_count(20, r, f, l, fr, ff, fl);
    chk_int("t4_lo_glitch_rises", br + r, 0); chk_int("t4_lo_glitch_falls", bf + f, 0);
    chk("t4_lo_glitch_clean", bus.btn_clean, 1'b1);

    // Reset while pressed
    #2 rst = 1'b1;
    #1;
    chk("t5_async_clean", bus.btn_clean, 1'b0);
    chk("t5_async_fall",  bus.btn_fall,  1'b0);
    model_reset();
    tick();
    #2 rst = 1'b0;
    run_count(20, r, f, l, fr, ff, fl);
    chk_int("t5_rise_edge", fr, SYNC + DEB); chk_int("t5_rises", r, 1); chk_int("t5_falls", f, 0);

    // Long hold
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);
    set_btn(1'b1); run_count(30, r, f, l, fr, ff, fl);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    chk_int("t6_longs", l, 1);
    chk_int("t6_long_delay", fl - fr, LONG);
`else
    chk_int("t6_longs", l, 0);
`endif
    set_btn(1'b0); run_count(20, r, f, l, fr, ff, fl);

    // Random button levels with random hold lengths
    for (int k = 0; k < 80; k++) begin
      set_btn(1'($urandom_range(0, 1)));
      run_count($urandom_range(1, 8), r, f, l, fr, ff, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
